pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It drives write-enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken branches resolved in MEM, and multi-cycle data-memory waits, and watches for memory timeout. It sits beside the datapath and is fed from the ID stage, the EX/MEM register outputs and the data-memory ready line.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 37 +++
 rtl/pipeline_hazard_ctrl_if.sv | 59 +++++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - FSM state encoding (RUN / MEM_WAIT / ERROR)
//   - REG_ZERO, the hard-wired zero register that never causes a hazard
//   - pipe_ctrl_t, the bundle of enable/flush controls driven to the datapath
//   - load_use_hit(), the load-use hazard detector
package pipeline_hazard_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic fd_write;
    logic dx_write;
    logic xm_write;
    logic mw_write;
    logic fd_flush;
    logic dx_flush;
    logic xm_flush;
    logic mw_flush;
  } pipe_ctrl_t;

  // A load in EX whose destination is read by the instruction in ID.
  // Writes to the zero register are discarded, so they never create a hazard.
  function automatic logic load_use_hit(input logic       ex_mem_read,
                                        input logic [4:0] ex_rd,
                                        input logic [4:0] id_rs,
                                        input logic [4:0] id_rt,
                                        input logic       id_uses_rt);
    return ex_mem_read && (ex_rd != REG_ZERO) &&
           ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the datapath and the hazard controller.
//   Inputs to the controller : id_rs, id_rt, id_uses_rt, ex_mem_read,
//                              ex_write_reg_addr, mem_branch_taken,
//                              mem_req, mem_ready
//   Outputs of the controller: pc/fd/dx/xm/mw_write, fd/dx/xm/mw_flush,
//                              mem_timeout, stall_count, flush_count,
//                              dbg_state (current FSM state)
//
// Memory handshake: mem_req is the request (valid) held by the MEM stage for
// as long as its access is outstanding; mem_ready is the completion (ready)
// from the data memory. The access completes in the cycle where both are 1.
// mem_req=1 with mem_ready=0 freezes the front of the pipeline; mem_ready
// has no meaning while mem_req=0.
// Modports: master = datapath side, slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipeline_hazard_ctrl_pkg::*;

  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_write_reg_addr;
  logic             mem_branch_taken;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_write;
  logic             fd_write;
  logic             dx_write;
  logic             xm_write;
  logic             mw_write;
  logic             fd_flush;
  logic             dx_flush;
  logic             xm_flush;
  logic             mw_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic [1:0]       dbg_state;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_write_reg_addr,
           mem_branch_taken, mem_req, mem_ready,
    input  pc_write, fd_write, dx_write, xm_write, mw_write,
           fd_flush, dx_flush, xm_flush, mw_flush,
           mem_timeout, stall_count, flush_count, dbg_state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_write_reg_addr,
           mem_branch_taken, mem_req, mem_ready,
    output pc_write, fd_write, dx_write, xm_write, mw_write,
           fd_flush, dx_flush, xm_flush, mw_flush,
           mem_timeout, stall_count, flush_count, dbg_state
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with asynchronous active-high reset.
//   clk, rst : clock, asynchronous reset (clears the count)
//   en_i     : count one event on this edge
//   count_o  : current count, sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
//   clk, rst : clock, asynchronous active-high reset
//   hz       : slave side of pipeline_hazard_ctrl_if (hazard inputs from
//              ID / EX / MEM, enable and flush controls for PC and the four
//              pipeline registers, timeout flag, performance counters,
//              FSM state for debug)
// Controls are combinational from the FSM state and the current inputs.
// Priority: error freeze > memory freeze > branch flush > load-use > run.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int WAIT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;

  logic              freeze;
  logic              load_use;
  logic              branch_flush;
  logic              timeout_hit;
  pipe_ctrl_t        ctrl;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  // ERROR owns the pipeline outright, so nothing below it may act there.
  assign freeze       = (state_q != ST_ERROR) && hz.mem_req && !hz.mem_ready;
  assign branch_flush = (state_q != ST_ERROR) && !freeze && hz.mem_branch_taken;
  assign load_use     = load_use_hit(hz.ex_mem_read, hz.ex_write_reg_addr,
                                     hz.id_rs, hz.id_rt, hz.id_uses_rt);
  assign timeout_hit  = (MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT));

  always_comb begin
    ctrl = '0;
    if (rst) begin
      ctrl.fd_flush = 1'b1;
      ctrl.dx_flush = 1'b1;
      ctrl.xm_flush = 1'b1;
      ctrl.mw_flush = 1'b1;
    end else if (state_q == ST_ERROR) begin
      ctrl = '0;
    end else if (freeze) begin
      // WB keeps clocking but takes a bubble, so the instruction stuck in
      // MEM is not written back twice.
      ctrl.mw_write = 1'b1;
      ctrl.mw_flush = 1'b1;
    end else if (branch_flush) begin
      // The ID instruction is squashed here, so load-use does not matter.
      ctrl.pc_write = 1'b1;
      ctrl.fd_write = 1'b1;
      ctrl.dx_write = 1'b1;
      ctrl.xm_write = 1'b1;
      ctrl.mw_write = 1'b1;
      ctrl.fd_flush = 1'b1;
      ctrl.dx_flush = 1'b1;
      ctrl.xm_flush = 1'b1;
    end else if (load_use) begin
      // One bubble suffices: the load moves out of EX on this edge.
      ctrl.dx_write = 1'b1;
      ctrl.dx_flush = 1'b1;
      ctrl.xm_write = 1'b1;
      ctrl.mw_write = 1'b1;
    end else begin
      ctrl.pc_write = 1'b1;
      ctrl.fd_write = 1'b1;
      ctrl.dx_write = 1'b1;
      ctrl.xm_write = 1'b1;
      ctrl.mw_write = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (freeze) begin
          if (timeout_hit) begin
            state_d = ST_ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          // Release is already visible in this cycle's controls.
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (!ctrl.pc_write),
    .count_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (branch_flush),
    .count_o (flush_cnt)
  );

  assign hz.pc_write    = ctrl.pc_write;
  assign hz.fd_write    = ctrl.fd_write;
  assign hz.dx_write    = ctrl.dx_write;
  assign hz.xm_write    = ctrl.xm_write;
  assign hz.mw_write    = ctrl.mw_write;
  assign hz.fd_flush    = ctrl.fd_flush;
  assign hz.dx_flush    = ctrl.dx_flush;
  assign hz.xm_flush    = ctrl.xm_flush;
  assign hz.mw_flush    = ctrl.mw_flush;
  assign hz.mem_timeout = (state_q == ST_ERROR);
  assign hz.stall_count = stall_cnt;
  assign hz.flush_count = flush_cnt;
  assign hz.dbg_state   = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: table vectors, hand sequences for the
// multi-cycle cases, then random traffic checked against a run-length model.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  localparam int T    = 4;
  localparam int CW   = 8;
  localparam int CMAX = 255;

  // Output vector layout: {pc,fd,dx,xm,mw write, fd,dx,xm,mw flush, timeout}
  localparam logic [9:0] O_RUN    = 10'b11111_0000_0;
  localparam logic [9:0] O_LU     = 10'b00111_0100_0;
  localparam logic [9:0] O_BR     = 10'b11111_1110_0;
  localparam logic [9:0] O_FREEZE = 10'b00001_0001_0;
  localparam logic [9:0] O_ERR    = 10'b00000_0000_1;
  localparam logic [9:0] O_RST    = 10'b00000_1111_0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       ld;
    logic [4:0] rd;
    logic       br;
    logic       req;
    logic       rdy;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [9:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];

  // reference model: error flag, length of current freeze run, counters
  bit m_err;
  int m_run;
  int m_stall;
  int m_flush;

  function automatic in_t mk(int rs, int rt, bit uses, bit ld, int rd, bit br, bit req, bit rdy);
    in_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.uses_rt = uses; v.ld = ld;
    v.rd = 5'(rd); v.br = br; v.req = req; v.rdy = rdy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [9:0] dut_outs();
    return {hz.pc_write, hz.fd_write, hz.dx_write, hz.xm_write, hz.mw_write,
            hz.fd_flush, hz.dx_flush, hz.xm_flush, hz.mw_flush, hz.mem_timeout};
  endfunction

  // ---------------- model ----------------
  function automatic logic [9:0] model_out(input in_t v, input bit err);
    bit hit;
    hit = v.ld && (v.rd != 5'd0) && ((v.rd == v.rs) || (v.uses_rt && (v.rd == v.rt)));
    if (err)              return O_ERR;
    if (v.req && !v.rdy)  return O_FREEZE;
    if (v.br)             return O_BR;
    if (hit)              return O_LU;
    return O_RUN;
  endfunction

  function automatic logic [1:0] model_state();
    if (m_err)     return ST_ERROR;
    if (m_run > 0) return ST_MEM_WAIT;
    return ST_RUN;
  endfunction

  task automatic model_edge(input in_t v);
    logic [9:0] o;
    bit frozen;
    o = model_out(v, m_err);
    frozen = !m_err && v.req && !v.rdy;
    if (!o[9] && m_stall < CMAX) m_stall++;
    if (!m_err && !frozen && v.br && m_flush < CMAX) m_flush++;
    if (!m_err) begin
      if (frozen) begin
        m_run++;
        // the (T+1)-th consecutive frozen cycle is the one that times out
        if (T != 0 && m_run == T + 1) m_err = 1'b1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic model_reset();
    m_err = 1'b0; m_run = 0; m_stall = 0; m_flush = 0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic drive(input in_t v);
    hz.id_rs             = v.rs;
    hz.id_rt             = v.rt;
    hz.id_uses_rt        = v.uses_rt;
    hz.ex_mem_read       = v.ld;
    hz.ex_write_reg_addr = v.rd;
    hz.mem_branch_taken  = v.br;
    hz.mem_req           = v.req;
    hz.mem_ready         = v.rdy;
  endtask

  task automatic step(input in_t v, input string tag);
    logic [11:0] e;
    drive(v);
    exp_q.push_back({model_state(), model_out(v, m_err)});
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, "_ctrl"},  {hz.dbg_state, dut_outs()}, e);
    check({tag, "_stall"}, hz.stall_count, m_stall);
    check({tag, "_flush"}, hz.flush_count, m_flush);
    model_edge(v);
    @(posedge clk); #1;
  endtask

  task automatic step_tbl(input vec_t t);
    drive(t.in);
    @(negedge clk);
    check(t.name, dut_outs(), t.exp);
    model_edge(t.in);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_ctrl",  {hz.dbg_state, dut_outs()}, {ST_RUN, O_RST});
    check("rst_stall", hz.stall_count, 0);
    check("rst_flush", hz.flush_count, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl[13];
  in_t  frz;
  in_t  idle;
  in_t  v;
  int   req_pct;
  int   rdy_pct;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    frz  = mk(0, 0, 0, 0, 0, 0, 1, 0);
    tbl[0]  = '{"idle",       mk(0, 0, 0, 0, 0, 0, 0, 0), O_RUN};
    tbl[1]  = '{"lu_rs",      mk(8, 0, 0, 1, 8, 0, 0, 0), O_LU};
    tbl[2]  = '{"lu_after",   mk(8, 0, 0, 0, 0, 0, 0, 0), O_RUN};
    tbl[3]  = '{"zero_reg",   mk(0, 0, 1, 1, 0, 0, 0, 0), O_RUN};
    tbl[4]  = '{"rt_no_use",  mk(1, 9, 0, 1, 9, 0, 0, 0), O_RUN};
    tbl[5]  = '{"rt_use",     mk(1, 9, 1, 1, 9, 0, 0, 0), O_LU};
    tbl[6]  = '{"no_load",    mk(8, 8, 1, 0, 8, 0, 0, 0), O_RUN};
    tbl[7]  = '{"br_lu",      mk(8, 0, 0, 1, 8, 1, 0, 0), O_BR};
    tbl[8]  = '{"br",         mk(3, 4, 1, 0, 0, 1, 0, 0), O_BR};
    tbl[9]  = '{"req_rdy",    mk(0, 0, 0, 0, 0, 0, 1, 1), O_RUN};
    tbl[10] = '{"freeze",     mk(0, 0, 0, 0, 0, 0, 1, 0), O_FREEZE};
    tbl[11] = '{"freeze_br",  mk(8, 0, 0, 1, 8, 1, 1, 0), O_FREEZE};
    tbl[12] = '{"release_br", mk(0, 0, 0, 0, 0, 1, 1, 1), O_BR};

    drive(idle);
    @(posedge clk); #1;
    do_reset();

    // table vectors
    for (int i = 0; i < 13; i++) step_tbl(tbl[i]);
    check("tbl_stall", hz.stall_count, 4);
    check("tbl_flush", hz.flush_count, 3);
    check("tbl_state", hz.dbg_state, ST_RUN);

    // load-use: exactly one bubble
    do_reset();
    step(mk(8, 0, 0, 1, 8, 0, 0, 0), "lu1");
    check("lu1_stall_after", hz.stall_count, 1);
    step(mk(8, 0, 0, 0, 0, 0, 0, 0), "lu1_next");

    // memory wait: three frozen cycles, release in the fourth
    do_reset();
    for (int i = 0; i < 3; i++) step(frz, "mwait");
    check("mwait_state", hz.dbg_state, ST_MEM_WAIT);
    check("mwait_stall", hz.stall_count, 3);
    step(mk(0, 0, 0, 0, 0, 0, 1, 1), "mwait_rel");
    check("mwait_rel_state", hz.dbg_state, ST_RUN);

    // timeout: sticky, mem_ready does not recover
    do_reset();
    for (int i = 0; i < T + 1; i++) step(frz, "tmo");
    check("tmo_state", hz.dbg_state, ST_ERROR);
    check("tmo_flag",  hz.mem_timeout, 1);
    for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 0, 1, 1, 1), "tmo_stuck");
    check("tmo_sticky", hz.mem_timeout, 1);
    check("tmo_stall",  hz.stall_count, T + 4);

    // asynchronous reset between edges, in MEM_WAIT
    do_reset();
    step(frz, "ar");
    step(frz, "ar");
    #2;
    rst = 1'b1;
    #1;
    check("ar_state", hz.dbg_state, ST_RUN);
    check("ar_stall", hz.stall_count, 0);
    check("ar_tmo",   hz.mem_timeout, 0);
    check("ar_ctrl",  dut_outs(), O_RST);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    // counter saturation
    do_reset();
    for (int i = 0; i < T + 1; i++) step(frz, "sat_s");
    for (int i = 0; i < CMAX + 5; i++) step(idle, "sat_s");
    check("sat_stall", hz.stall_count, CMAX);
    do_reset();
    for (int i = 0; i < CMAX + 5; i++) step(mk(0, 0, 0, 0, 0, 1, 0, 0), "sat_f");
    check("sat_flush", hz.flush_count, CMAX);

    // random traffic in phases of fast / slow memory
    do_reset();
    req_pct = 40;
    rdy_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        req_pct = ($urandom_range(0, 1) == 0) ? 40 : 90;
        case ($urandom_range(0, 2))
          0:       rdy_pct = 10;
          1:       rdy_pct = 60;
          default: rdy_pct = 95;
        endcase
      end
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        v = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom_range(0, 3),
               ($urandom_range(0, 99) < 20),
               ($urandom_range(0, 99) < req_pct),
               ($urandom_range(0, 99) < rdy_pct));
        step(v, "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
